// File: rtl/mbssoc_int_collector_if.sv
// Interface bundling the interrupt lines, the distributor handshake and the config bus
// of mbssoc_int_collector; the collector sits on the slave side.
interface mbssoc_int_collector_if #(
    parameter int NUM_SRC = 7
);
    logic [NUM_SRC-1:0] irq_in;
    logic [NUM_SRC-1:0] int_ack;
    logic [NUM_SRC-1:0] int_vec;
    logic               cfg_we;
    logic [1:0]         cfg_addr;
    logic [NUM_SRC-1:0] cfg_wdata;
    logic [NUM_SRC-1:0] cfg_rdata;
    logic [NUM_SRC-1:0] overflow;

    modport master (
        output irq_in, int_ack, cfg_we, cfg_addr, cfg_wdata,
        input  int_vec, cfg_rdata, overflow
    );

    modport slave (
        input  irq_in, int_ack, cfg_we, cfg_addr, cfg_wdata,
        output int_vec, cfg_rdata, overflow
    );
endinterface

// File: rtl/mbssoc_int_collector.sv
// Interrupt collector: synchronises device lines, latches edge/level events per source,
// queues edge bursts and presents masked pending events to the interrupt distributor.
module mbssoc_int_collector #(
    parameter int NUM_SRC   = 7,
    parameter int CNT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mbssoc_int_collector_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PEND     = 2'd1,
        ST_GAP      = 2'd2,
        ST_WAIT_REL = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic [NUM_SRC-1:0]   r_s1, r_s2, r_s3;
    logic [NUM_SRC-1:0]   r_ack_d;
    logic [NUM_SRC-1:0]   r_mask, r_mode, r_ovf;
    state_t               r_state [NUM_SRC];
    logic [CNT_WIDTH-1:0] r_cnt   [NUM_SRC];

    logic [NUM_SRC-1:0] w_edge, w_lvl, w_pend, w_vec, w_ack_hon;
    logic [NUM_SRC-1:0] w_force, w_cnt_inc, w_ovf_set;
    logic               w_wr_mask, w_wr_mode, w_wr_pend, w_wr_ovf;

    assign w_edge    = r_s2 & ~r_s3;
    assign w_lvl     = r_s2;
    assign w_wr_mask = bus.cfg_we && (bus.cfg_addr == 2'd0);
    assign w_wr_mode = bus.cfg_we && (bus.cfg_addr == 2'd1);
    assign w_wr_pend = bus.cfg_we && (bus.cfg_addr == 2'd2);
    assign w_wr_ovf  = bus.cfg_we && (bus.cfg_addr == 2'd3);

    // A PENDING W1C or a changed MODE bit overrides everything else for that source.
    assign w_force   = (w_wr_pend ? bus.cfg_wdata : '0)
                     | (w_wr_mode ? (bus.cfg_wdata ^ r_mode) : '0);
    assign w_vec     = w_pend & ~r_mask;
    assign w_ack_hon = bus.int_ack & ~r_ack_d & w_vec;

    always_comb begin
        w_pend    = '0;
        w_cnt_inc = '0;
        w_ovf_set = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            w_pend[i] = (r_state[i] == ST_PEND);
            // Edges are only queued while an event is already outstanding.
            if (!w_force[i] && r_mode[i] && w_edge[i] &&
                ((r_state[i] == ST_PEND) || (r_state[i] == ST_GAP))) begin
                w_cnt_inc[i] = (r_cnt[i] != CNT_MAX);
                w_ovf_set[i] = (r_cnt[i] == CNT_MAX);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1    <= '0;
            r_s2    <= '0;
            r_s3    <= '0;
            r_ack_d <= '0;
            r_mask  <= '1;
            r_mode  <= '1;
            r_ovf   <= '0;
            for (int i = 0; i < NUM_SRC; i++) begin
                r_state[i] <= ST_IDLE;
                r_cnt[i]   <= '0;
            end
        end else begin
            r_s1    <= bus.irq_in;
            r_s2    <= r_s1;
            r_s3    <= r_s2;
            r_ack_d <= bus.int_ack;
            if (w_wr_mask) r_mask <= bus.cfg_wdata;
            if (w_wr_mode) r_mode <= bus.cfg_wdata;
            r_ovf <= (r_ovf & ~(w_wr_ovf ? bus.cfg_wdata : '0)) | w_ovf_set;

            for (int i = 0; i < NUM_SRC; i++) begin
                if (w_force[i]) begin
                    r_state[i] <= ST_IDLE;
                    r_cnt[i]   <= '0;
                end else begin
                    case (r_state[i])
                        ST_IDLE: begin
                            if (r_mode[i] ? w_edge[i] : w_lvl[i]) r_state[i] <= ST_PEND;
                        end
                        ST_PEND: begin
                            if (w_cnt_inc[i]) r_cnt[i] <= r_cnt[i] + CNT_ONE;
                            if (w_ack_hon[i]) r_state[i] <= r_mode[i] ? ST_GAP : ST_WAIT_REL;
                        end
                        ST_GAP: begin
                            // An edge landing in the gap is presented directly, so the count nets out.
                            if (w_cnt_inc[i]) begin
                                r_state[i] <= ST_PEND;
                            end else if (r_cnt[i] != '0) begin
                                r_cnt[i]   <= r_cnt[i] - CNT_ONE;
                                r_state[i] <= ST_PEND;
                            end else begin
                                r_state[i] <= ST_IDLE;
                            end
                        end
                        ST_WAIT_REL: begin
                            if (!w_lvl[i]) r_state[i] <= ST_IDLE;
                        end
                        default: r_state[i] <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign bus.int_vec  = w_vec;
    assign bus.overflow = r_ovf;

    always_comb begin
        bus.cfg_rdata = '0;
        case (bus.cfg_addr)
            2'd0:    bus.cfg_rdata = r_mask;
            2'd1:    bus.cfg_rdata = r_mode;
            2'd2:    bus.cfg_rdata = w_pend;
            default: bus.cfg_rdata = r_ovf;
        endcase
    end
endmodule

// File: tb/tb_mbssoc_int_collector.sv
// Bench for mbssoc_int_collector: directed scenarios then random traffic, all checked
// every cycle against an event-count reference model of each source.
module tb_mbssoc_int_collector;
    localparam int N    = 7;
    localparam int QMAX = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mbssoc_int_collector_if #(.NUM_SRC(N)) bus ();

    mbssoc_int_collector #(.NUM_SRC(N), .CNT_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: outstanding events per source, plus "in the one-cycle gap" and
    // "acked level, waiting for release" flags; the line history replaces the synchroniser.
    bit [N-1:0] m_mask, m_mode, m_ovf, m_ackd;
    bit [N-1:0] m_h1, m_h2, m_h3;
    bit [N-1:0] m_gap, m_held;
    int         m_ev [N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit [N-1:0] m_present();
        bit [N-1:0] p;
        p = '0;
        for (int i = 0; i < N; i++) p[i] = (m_ev[i] > 0) && !m_gap[i] && !m_held[i];
        return p;
    endfunction

    function automatic bit [N-1:0] m_rdata(input logic [1:0] a);
        case (a)
            2'd0:    return m_mask;
            2'd1:    return m_mode;
            2'd2:    return m_present();
            default: return m_ovf;
        endcase
    endfunction

    task automatic model_reset();
        m_mask = '1; m_mode = '1; m_ovf = '0; m_ackd = '0;
        m_h1 = '0; m_h2 = '0; m_h3 = '0; m_gap = '0; m_held = '0;
        for (int i = 0; i < N; i++) m_ev[i] = 0;
    endtask

    task automatic model_step();
        bit [N-1:0] vec, edg, lvl, hon, frc, onew;
        vec  = m_present() & ~m_mask;
        edg  = m_h2 & ~m_h3;
        lvl  = m_h2;
        hon  = bus.int_ack & ~m_ackd & vec;
        frc  = '0;
        onew = '0;
        if (bus.cfg_we && bus.cfg_addr == 2'd2) frc |= bus.cfg_wdata;
        if (bus.cfg_we && bus.cfg_addr == 2'd1) frc |= bus.cfg_wdata ^ m_mode;
        for (int i = 0; i < N; i++) begin
            if (frc[i]) begin
                m_ev[i] = 0; m_gap[i] = 0; m_held[i] = 0;
            end else if (m_mode[i]) begin
                if (m_gap[i]) begin
                    // in the gap the event count equals the queue depth
                    m_gap[i] = 0;
                    if (edg[i]) begin
                        if (m_ev[i] < QMAX) m_ev[i]++; else onew[i] = 1;
                    end
                end else if (m_ev[i] > 0) begin
                    // presented event plus up to QMAX queued ones
                    if (edg[i]) begin
                        if (m_ev[i] < QMAX + 1) m_ev[i]++; else onew[i] = 1;
                    end
                    if (hon[i]) begin
                        m_ev[i]--; m_gap[i] = 1;
                    end
                end else if (edg[i]) begin
                    m_ev[i] = 1;
                end
            end else begin
                if (m_held[i]) begin
                    if (!lvl[i]) m_held[i] = 0;
                end else if (m_ev[i] > 0) begin
                    if (hon[i]) begin
                        m_ev[i] = 0; m_held[i] = 1;
                    end
                end else if (lvl[i]) begin
                    m_ev[i] = 1;
                end
            end
        end
        m_h3 = m_h2; m_h2 = m_h1; m_h1 = bus.irq_in;
        m_ackd = bus.int_ack;
        if (bus.cfg_we) begin
            case (bus.cfg_addr)
                2'd0:    m_mask = bus.cfg_wdata;
                2'd1:    m_mode = bus.cfg_wdata;
                2'd3:    m_ovf  = m_ovf & ~bus.cfg_wdata;
                default: ;
            endcase
        end
        m_ovf |= onew;
    endtask

    task automatic check_out(input string tag);
        chk({tag, ".int_vec"},  bus.int_vec,   m_present() & ~m_mask);
        chk({tag, ".overflow"}, bus.overflow,  m_ovf);
        chk({tag, ".rdata"},    bus.cfg_rdata, m_rdata(bus.cfg_addr));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_out("cyc");
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [N-1:0] d);
        bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
        cyc();
        bus.cfg_we = 1'b0; bus.cfg_wdata = '0;
    endtask

    task automatic pulse(input int s, input int gap_cycles);
        bus.irq_in[s] = 1'b1;
        cyc();
        bus.irq_in[s] = 1'b0;
        for (int k = 0; k < gap_cycles; k++) cyc();
    endtask

    task automatic wait_vec(input int s);
        bit seen;
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (bus.int_vec[s]) seen = 1;
            else cyc();
        end
        chk("wait_vec", 32'(seen), 32'd1);
    endtask

    task automatic ack(input int s);
        bus.int_ack[s] = 1'b1;
        cyc();
        bus.int_ack[s] = 1'b0;
        cyc();
    endtask

    initial begin
        bus.irq_in = '0; bus.int_ack = '0;
        bus.cfg_we = 1'b0; bus.cfg_addr = 2'd0; bus.cfg_wdata = '0;
        model_reset();
        @(negedge clk);
        check_out("reset");
        chk("reset_mask_read", bus.cfg_rdata, 32'h7F);
        rst = 1'b0;

        // Single edge event: latency and ack
        cfg_write(2'd0, 7'h00);
        cfg_write(2'd1, 7'h7F);
        bus.irq_in[3] = 1'b1;
        cyc();
        bus.irq_in[3] = 1'b0;
        cyc();
        chk("assert_early", bus.int_vec, 32'h00);
        cyc();
        chk("assert_lat", bus.int_vec, 32'h08);
        bus.int_ack[3] = 1'b1;
        bus.cfg_addr = 2'd2;
        cyc();
        chk("ack_drop", bus.int_vec, 32'h00);
        chk("ack_pending", bus.cfg_rdata, 32'h00);
        bus.int_ack[3] = 1'b0;
        cyc();

        // Edge burst queued, then drained one ack at a time
        for (int p = 0; p < 5; p++) pulse(1, 2);
        chk("burst_vec", bus.int_vec, 32'h02);
        for (int p = 0; p < 5; p++) begin
            wait_vec(1);
            ack(1);
        end
        for (int k = 0; k < 4; k++) cyc();
        chk("burst_idle", bus.int_vec, 32'h00);

        // Queue overflow
        for (int p = 0; p < 17; p++) pulse(0, 2);
        chk("ovf_flag", bus.overflow, 32'h01);
        cfg_write(2'd3, 7'h01);
        chk("ovf_clear", bus.overflow, 32'h00);
        cfg_write(2'd2, 7'h01);
        chk("w1c_clear", bus.int_vec, 32'h00);

        // Level mode
        cfg_write(2'd1, 7'h7B);
        bus.irq_in[2] = 1'b1;
        wait_vec(2);
        ack(2);
        for (int k = 0; k < 5; k++) cyc();
        chk("lvl_wait_rel", bus.int_vec, 32'h00);
        bus.irq_in[2] = 1'b0;
        for (int k = 0; k < 4; k++) cyc();
        bus.irq_in[2] = 1'b1;
        cyc(); cyc(); cyc();
        chk("lvl_reassert", bus.int_vec, 32'h04);
        bus.irq_in[2] = 1'b0;
        cfg_write(2'd1, 7'h7F);

        // Masked source still pends; unmask presents it
        cfg_write(2'd0, 7'h04);
        pulse(2, 2);
        bus.cfg_addr = 2'd2;
        cyc();
        chk("mask_vec", bus.int_vec, 32'h00);
        chk("mask_pending", bus.cfg_rdata, 32'h04);
        ack(2);
        cfg_write(2'd0, 7'h00);
        chk("unmask_vec", bus.int_vec, 32'h04);
        ack(2);

        // Async reset mid-burst
        for (int p = 0; p < 4; p++) pulse(5, 2);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_out("async_rst");
        chk("async_rst_vec", bus.int_vec, 32'h00);
        @(negedge clk);
        check_out("rst_hold");
        rst = 1'b0;
        cfg_write(2'd0, 7'h00);
        for (int k = 0; k < 6; k++) cyc();
        chk("post_rst_vec", bus.int_vec, 32'h00);

        // Random traffic
        for (int k = 0; k < 2000; k++) begin
            bus.irq_in  = N'($urandom & $urandom & $urandom);
            bus.int_ack = N'($urandom & $urandom);
            bus.cfg_addr = 2'($urandom_range(0, 3));
            bus.cfg_we  = ($urandom_range(0, 15) == 0);
            if (bus.cfg_addr == 2'd0) bus.cfg_wdata = N'($urandom & $urandom & $urandom);
            else if (bus.cfg_addr == 2'd1) bus.cfg_wdata = N'($urandom | $urandom);
            else bus.cfg_wdata = N'($urandom);
            cyc();
        end
        bus.cfg_we = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
